// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode map, sequencer state type
// and the op-dependent hold latency helper.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MULT = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOR  = 5'd7;
  localparam logic [4:0] OP_LT   = 5'd8;
  localparam logic [4:0] OP_EQ   = 5'd9;
  localparam logic [4:0] OP_NE   = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_SHR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_seq_state_t;

  // Number of cycles the ALU inputs are held before the result is captured.
  function automatic int unsigned op_latency(input logic [4:0] op,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    if (op == OP_MULT) return mul_lat;
    if (op == OP_DIV)  return div_lat;
    return 1;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way combinational grant. Default: round-robin against last_grant.
// With ALU_SEQ_FIXED_PRIO_EN defined, req0 always wins contention.
module alu_rr_pick
  import alu_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_any,
  output logic       grant_id
);

`ifdef ALU_SEQ_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_grant;

  // Fixed priority: requester 1 wins only when requester 0 is idle.
  always_comb begin
    grant_any = |valid;
    grant_id  = ~valid[0];
  end
`else
  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    grant_any = |valid;
    grant_id  = (valid == 2'b11) ? ~last_grant : valid[1];
  end
`endif

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one ALU between two requesters: arbitrates, registers the winner's
// operands into the ALU inputs, holds them for an op-dependent latency and
// captures the result into a tagged response register.
// Build option: ALU_SEQ_FIXED_PRIO_EN selects fixed priority (req0 wins).
module alu_req_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [9:0]           req_op,
  input  logic [1:0]           req_imm,
  input  logic [2*ALU_W-1:0]   req_a,
  input  logic [2*ALU_W-1:0]   req_b,
  input  logic [2*ALU_W-1:0]   req_ext,
  output logic [4:0]           alu_op,
  output logic                 alu_imm,
  output logic [ALU_W-1:0]     alu_a,
  output logic [ALU_W-1:0]     alu_b,
  output logic [ALU_W-1:0]     alu_ext,
  input  logic [ALU_W-1:0]     alu_result,
  input  logic                 alu_true,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [ALU_W-1:0]     rsp_result,
  output logic                 rsp_true
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  alu_seq_state_t   state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cur_id;
  logic             last_grant;
  logic             grant_any, grant_id;
  logic             accept, capture;
  logic [4:0]       sel_op;
  logic             sel_imm;
  logic [ALU_W-1:0] sel_a, sel_b, sel_ext;
  logic [ALU_W-1:0] cap_result;
  logic             cap_true;

  alu_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant_any  (grant_any),
    .grant_id   (grant_id)
  );

  // Winner's request fields.
  always_comb begin
    sel_op  = grant_id ? req_op[9:5]             : req_op[4:0];
    sel_imm = grant_id ? req_imm[1]              : req_imm[0];
    sel_a   = grant_id ? req_a[2*ALU_W-1:ALU_W]  : req_a[ALU_W-1:0];
    sel_b   = grant_id ? req_b[2*ALU_W-1:ALU_W]  : req_b[ALU_W-1:0];
    sel_ext = grant_id ? req_ext[2*ALU_W-1:ALU_W] : req_ext[ALU_W-1:0];
  end

  // Result to capture: divide-by-zero and unsupported ops override the ALU.
  always_comb begin
    cap_result = alu_result;
    cap_true   = alu_true;
    if (alu_op == OP_DIV && alu_b == '0) begin
      cap_result = '1;
      cap_true   = 1'b0;
    end else if (alu_op >= OP_NOP) begin
      cap_result = '0;
      cap_true   = 1'b0;
    end
  end

  // Next-state, accept slot and request handshake.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    req_ready  = '0;
    unique case (state)
      ST_IDLE: accept = grant_any;
      ST_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          accept     = grant_any;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) accept = 1'b0;
    if (accept) begin
      state_next          = ST_BUSY;
      req_ready[grant_id] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // ALU input registers, hold counter and response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op     <= '0;
      alu_imm    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ext    <= '0;
      cnt        <= '0;
      cur_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_true   <= 1'b0;
    end else begin
      if (accept) begin
        alu_op  <= sel_op;
        alu_imm <= sel_imm;
        alu_a   <= sel_a;
        alu_b   <= sel_b;
        alu_ext <= sel_ext;
        cnt     <= CNT_W'(op_latency(sel_op, MUL_LAT, DIV_LAT));
        cur_id  <= grant_id;
      end else if (state == ST_BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= cur_id;
        rsp_result <= cap_result;
        rsp_true   <= cap_true;
      end else if (state == ST_DONE && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_FIXED_PRIO_EN
  assign last_grant = 1'b1;
`else
  // Round-robin history: remembers who was granted on the last accept.
  always_ff @(posedge clk) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= grant_id;
  end
`endif

endmodule

// File: doc/alu_req_sequencer.md
# alu_req_sequencer

Front-end controller that shares the single 32-bit ALU between two requesters (req0: execute stage, req1: address/branch unit). Arbitrates with valid/ready handshakes, latches the winner's operands into the ALU input registers, holds them for an op-dependent number of cycles so MULT/DIV can be multi-cycle, then captures `Resultado`/`True` into a response register tagged with the requester ID. It sits directly in front of the ALU and is its only driver.

## Interface

Parameters:
- `MUL_LAT`, 3: cycles ALU inputs are held for op 2 (MULT). Must be ≥1.
- `DIV_LAT`, 8: cycles ALU inputs are held for op 3 (DIV). Must be ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid[1:0]`  in  2  request present, per requester.
- `req_ready[1:0]`  out  2  request accepted this edge when paired with valid.
- `req_op[i]`  in  5  ALU opcode, per requester.
- `req_imm[i]`  in  1  immediate select, per requester.
- `req_a[i]`, `req_b[i]`, `req_ext[i]`  in  32 each  operands `Lido1`, `Lido2` and `estendido`, per requester.
- `alu_op`  out  5, `alu_imm`  out  1, `alu_a`/`alu_b`/`alu_ext`  out  32  registered ALU inputs.
- `alu_result`  in  32, `alu_true`  in  1  ALU outputs.
- `rsp_valid`  out  1, `rsp_ready`  in  1  response handshake.
- `rsp_id`  out  1  requester index of the response.
- `rsp_result`  out  32, `rsp_true`  out  1  captured result and flag.

## Operation

- States: IDLE, BUSY, DONE.
- Grant, computed combinationally from `req_valid`:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins (`last_grant` register).
  - `req_ready` is high only for the winner, and only in IDLE, or in DONE with `rsp_ready`=1.
- On accept:
  - Register op, imm and operands into the `alu_*` outputs.
  - Load `cnt` = `MUL_LAT` for op 2, `DIV_LAT` for op 3, and 1 for all other ops.
  - Record the ID, update `last_grant`, go to BUSY.
- BUSY:
  - Decrement `cnt` each cycle.
  - On the edge where `cnt`==1, capture `alu_result`/`alu_true` into `rsp_*`, assert `rsp_valid`, go to DONE.
- DONE:
  - Hold `rsp_*` stable until `rsp_ready`.
  - If `rsp_ready`=1 and a new request is accepted on the same edge, go to BUSY and deassert `rsp_valid`.
  - If `rsp_ready`=1 and no request is accepted, go to IDLE.
- Divide by zero (op 3, `req_b`=0): `rsp_result` = 32'hFFFFFFFF, `rsp_true` = 0. Latency is still `DIV_LAT`.
- Op 13 and ops 14–31: latency 1, `rsp_result` = 0, `rsp_true` = 0. The ALU output is ignored.
- The `alu_*` outputs keep their last value outside BUSY; they are never driven with partial updates.
- Reset values: all outputs 0, state IDLE, `cnt` 0, `last_grant` = 1 (req0 wins the first contention).
- Reset mid-operation: any in-flight op and any pending response are discarded with no response.

## Timing

- Accept on edge k. For latency L, `rsp_valid` rises at edge k+L.
- Simple op: response in the cycle after accept.
- Peak throughput: one simple op per 2 cycles (accept in DONE overlaps with response retirement).
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`; there is no combinational path from `alu_*` to `req_ready`.
- Requesters must hold `req_*` stable while valid and not ready.

## Configuration

- `ALU_SEQ_FIXED_PRIO_EN`:
  - Defined: req0 always wins contention; `last_grant` is not implemented.
  - Undefined (default): round-robin as described above.

## Structure

- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD`=0 … `OP_SHR`=12, `OP_NOP`=13;
  - state enum `alu_seq_state_t`;
  - `ALU_W`=32.
- One sub-module, `alu_rr_pick`: 2-way combinational grant from valids and `last_grant`, with the fixed-priority variant under the macro.

## Test plan

- req0 ADD a=5, b=7, imm=0 -> `req_ready[0]`=1 on accept edge; next cycle `rsp_valid`=1, `rsp_result`=12, `rsp_id`=0.
- Both valid continuously, `rsp_ready`=1 -> grants alternate 0,1,0,1; each response carries the matching ID.
- req1 MULT 6×7 with `MUL_LAT`=3 -> `rsp_valid` exactly 3 cycles after accept, result 42; `req_ready`=0 throughout BUSY.
- DIV 10/0 -> after `DIV_LAT` cycles, `rsp_result`=FFFFFFFF, `rsp_true`=0. Separately, LT 3<9 -> `rsp_result`=1, `rsp_true`=1.
- Hold `rsp_ready`=0 for 4 cycles in DONE -> `rsp_*` stable and `req_ready`=0; then `rsp_ready`=1 with req0 valid -> accept on the same edge.
- Assert `reset` during BUSY of a DIV -> next cycle state IDLE, `rsp_valid`=0, all `alu_*`=0, and no response is ever produced for the dropped op.
